// File: rtl/irq_sched.sv
// Interrupt scheduler: periodic tick timer (source 0) plus edge-captured external
// requests, shared onto one ei_req line with round-robin arbitration and an ack handshake.
module irq_sched #(
  parameter int N_SRC          = 4,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 6249,
  parameter int GAP_CYC        = 2,
  localparam int ID_W          = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             period_wr,
  input  logic [CNT_W-1:0] period_wdata,
  input  logic             tick_en,
  input  logic [N_SRC-2:0] src_req,
  input  logic [N_SRC-1:0] src_mask,
  input  logic             ack,
  input  logic             overrun_clr,
  output logic             ei_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun,
  output logic [1:0]       state_dbg
);

  // Handshake: ei_req=1 means irq_id is granted and frozen; the MCU answers with a
  // one-cycle ack while ei_req=1. ack seen in any other state is ignored.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       gap_q, gap_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, period_q;
  logic             tick;
  logic [N_SRC-2:0] req_q, prev_q;
  logic [N_SRC-1:0] event_vec, clr_vec, eligible;
  logic [N_SRC-1:0] pending_q, overrun_q;
  logic [ID_W-1:0]  pick;
  logic             found;
  logic             do_ack;

  // A period write restarts the count from zero and suppresses that cycle's tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= CNT_W'(DEFAULT_PERIOD);
    end else if (period_wr) begin
      cnt_q    <= '0;
      period_q <= period_wdata;
    end else if (tick_en) begin
      cnt_q <= (cnt_q == period_q) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= '0;
    end
  end

  assign tick = tick_en & ~period_wr & (cnt_q == period_q);

  // History resets to ones so a line already high at reset release is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q  <= '1;
      prev_q <= '1;
    end else begin
      req_q  <= src_req;
      prev_q <= req_q;
    end
  end

  assign event_vec = {req_q & ~prev_q, tick};
  assign do_ack    = (state_q == S_GRANT) && ack;
  assign clr_vec   = do_ack ? (N_SRC'(1) << irq_id_q) : '0;

  // New events win over both the ack clear and the overrun clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_vec) | event_vec;
      overrun_q <= (overrun_q & ~{N_SRC{overrun_clr}}) | (event_vec & pending_q & ~clr_vec);
    end
  end

  assign eligible = pending_q & ~src_mask;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      int j;
      j = int'(rr_q) + i;
      if (j >= N_SRC) j = j - N_SRC;
      if (!found && eligible[j]) begin
        found = 1'b1;
        pick  = ID_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      irq_id_q <= '0;
      rr_q     <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      irq_id_q <= irq_id_d;
      rr_q     <= rr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    irq_id_d = irq_id_q;
    rr_d     = rr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_GRANT;
          irq_id_d = pick;
        end
      end
      S_GRANT: begin
        // ack takes priority over a mask withdrawal in the same cycle.
        if (ack) begin
          state_d = S_GAP;
          gap_d   = '0;
          rr_d    = (irq_id_q == ID_W'(N_SRC - 1)) ? '0 : irq_id_q + ID_W'(1);
        end else if (src_mask[irq_id_q]) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 4'(GAP_CYC - 1)) state_d = S_IDLE;
        else gap_d = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ei_req    = (state_q == S_GRANT);
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule
